// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - shared PIO definitions: data width, error pattern, request FSM states
//
// Contents:
//   PIO_DW        host/slave data and address width
//   PIO_ERR_DATA  read data returned on decode errors and timeouts
//   pio_state_t   request controller state encoding
package pio_pkg;

  localparam int PIO_DW = 32;

  localparam logic [PIO_DW-1:0] PIO_ERR_DATA = 32'hBAD0_BAD0;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } pio_state_t;

endpackage

// File: rtl/pio_mem_req_ctrl.sv
// rtl/pio_mem_req_ctrl.sv - host PIO request controller fanning out to memory-mapped slaves
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   clk_div             host-rate qualifier; host requests are sampled only when high
//   pio_addr, pio_din   host byte address and write data
//   pio_rd, pio_wr      host read / write request
//   pio_ack             transaction complete (held in DONE)
//   pio_err, pio_rdata  error flag and read data, valid with pio_ack, held afterwards
//   reg_addr, reg_din   slave address / write data, held for the whole transaction
//   reg_rd, reg_wr      one-cycle slave strobes
//   reg_ms              one-hot slave select, held from ISSUE to the end of WAIT
//   mem_ack             per-slave ack levels
//   mem_rdata           per-slave read data, slave i at [32i+31:32i]
module pio_mem_req_ctrl
  import pio_pkg::*;
#(
  parameter int                NUM_SEL     = 4,
  parameter int                SEL_LSB     = 12,
  parameter int                TIMEOUT_CYC = 255,
  parameter logic [PIO_DW-1:0] ERR_DATA    = PIO_ERR_DATA
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      clk_div,
  input  logic [PIO_DW-1:0]         pio_addr,
  input  logic [PIO_DW-1:0]         pio_din,
  input  logic                      pio_rd,
  input  logic                      pio_wr,
  output logic                      pio_ack,
  output logic                      pio_err,
  output logic [PIO_DW-1:0]         pio_rdata,
  output logic [PIO_DW-1:0]         reg_addr,
  output logic [PIO_DW-1:0]         reg_din,
  output logic                      reg_rd,
  output logic                      reg_wr,
  output logic [NUM_SEL-1:0]        reg_ms,
  input  logic [NUM_SEL-1:0]        mem_ack,
  input  logic [NUM_SEL*PIO_DW-1:0] mem_rdata
);

  localparam int SEL_NBITS = (NUM_SEL > 1) ? $clog2(NUM_SEL) : 1;
  localparam int SEL_TOP   = SEL_LSB + SEL_NBITS;  // first address bit above the select field
  localparam int CNT_W     = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC + 1) : 1;
  localparam logic [SEL_NBITS:0] NUM_SEL_W  = (SEL_NBITS + 1)'(NUM_SEL);
  localparam logic [CNT_W-1:0]   CNT_LAST   = CNT_W'(TIMEOUT_CYC - 1);

  pio_state_t           state;
  logic [SEL_NBITS-1:0] idx;
  logic                 op_rd;
  logic [CNT_W-1:0]     cnt;
  logic [NUM_SEL-1:0]   ack_prev;

  logic [SEL_NBITS-1:0] req_idx;
  logic [NUM_SEL-1:0]   req_onehot;
  logic                 accept;
  logic                 req_bad;
  logic                 ack_rise;
  logic [PIO_DW-1:0]    sel_rdata;

  assign req_idx = pio_addr[SEL_TOP-1:SEL_LSB];

  // A stale ack from a previous transaction must drain before a new one may start,
  // otherwise its level could be mistaken for the new slave's response.
  assign accept  = clk_div && (pio_rd || pio_wr) && (mem_ack == '0);
  assign req_bad = (pio_rd && pio_wr)
                 || (|(pio_addr >> SEL_TOP))
                 || ({1'b0, req_idx} >= NUM_SEL_W);

  // Only the selected slave counts; completion is its ack's rising edge so that an
  // ack level still high from an earlier transfer cannot complete this one.
  always_comb begin
    req_onehot = '0;
    ack_rise   = 1'b0;
    sel_rdata  = '0;
    for (int i = 0; i < NUM_SEL; i++) begin
      req_onehot[i] = (req_idx == SEL_NBITS'(i));
      if (idx == SEL_NBITS'(i)) begin
        ack_rise  = mem_ack[i] && !ack_prev[i];
        sel_rdata = mem_rdata[i*PIO_DW +: PIO_DW];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      idx       <= '0;
      op_rd     <= 1'b0;
      cnt       <= '0;
      ack_prev  <= '0;
      pio_ack   <= 1'b0;
      pio_err   <= 1'b0;
      pio_rdata <= '0;
      reg_addr  <= '0;
      reg_din   <= '0;
      reg_rd    <= 1'b0;
      reg_wr    <= 1'b0;
      reg_ms    <= '0;
    end else begin
      ack_prev <= mem_ack;
      case (state)
        ST_IDLE: begin
          if (accept) begin
            if (req_bad) begin
              state     <= ST_DONE;
              pio_ack   <= 1'b1;
              pio_err   <= 1'b1;
              pio_rdata <= ERR_DATA;
            end else begin
              state    <= ST_ISSUE;
              idx      <= req_idx;
              op_rd    <= pio_rd;
              reg_addr <= pio_addr;
              reg_din  <= pio_din;
              reg_rd   <= pio_rd;
              reg_wr   <= pio_wr;
              reg_ms   <= req_onehot;
            end
          end
        end
        ST_ISSUE: begin
          state  <= ST_WAIT;
          reg_rd <= 1'b0;
          reg_wr <= 1'b0;
          cnt    <= '0;
        end
        ST_WAIT: begin
          // Completion is tested first so it wins over a timeout in the same cycle.
          if (ack_rise) begin
            state     <= ST_DONE;
            pio_ack   <= 1'b1;
            pio_err   <= 1'b0;
            pio_rdata <= op_rd ? sel_rdata : '0;
            reg_ms    <= '0;
          end else if (cnt == CNT_LAST) begin
            state     <= ST_DONE;
            pio_ack   <= 1'b1;
            pio_err   <= 1'b1;
            pio_rdata <= ERR_DATA;
            reg_ms    <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ST_DONE: begin
          if (clk_div) begin
            state   <= ST_IDLE;
            pio_ack <= 1'b0;
          end
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
